// File: rtl/apb_timer_multi_pkg.sv
// Shared register map, CTRL bit positions and mode encoding for the multi-channel APB timer.
package timer_multi_pkg;

  localparam logic [7:0] CH_STRIDE = 8'h10;

  localparam logic [3:0] OFF_LOAD   = 4'h0;
  localparam logic [3:0] OFF_CURVAL = 4'h4;
  localparam logic [3:0] OFF_CTRL   = 4'h8;
  localparam logic [3:0] OFF_EOI    = 4'hC;

  localparam logic [7:0] ADDR_INTSTAT = 8'hA0;
  localparam logic [7:0] ADDR_EOI_ALL = 8'hA4;
  localparam logic [7:0] ADDR_RAWINT  = 8'hA8;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_MODE    = 1;
  localparam int CTRL_MASK    = 2;
  localparam int CTRL_ONESHOT = 3;
  localparam int CTRL_PRESC   = 8;

  typedef enum logic {
    FREE_RUN = 1'b0,
    USER_DEF = 1'b1
  } mode_e;

endpackage

// File: rtl/apb_timer_multi_if.sv
// APB slave bus bundle for the timer; clock and reset stay outside the interface.
interface apb_timer_multi_if;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [7:0]  paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  modport master (output psel, penable, pwrite, paddr, pwdata,
                  input  prdata, pready, pslverr);
  modport slave  (input  psel, penable, pwrite, paddr, pwdata,
                  output prdata, pready, pslverr);
endinterface

// File: rtl/apb_timer_multi_chan.sv
// One timer channel: LOAD/CTRL registers, prescaler, down-counter, raw interrupt and trigger pulse.
module timer_multi_chan #(
  parameter int CNT_W   = 32,
  parameter int PRESC_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              wr_load_i,
  input  logic              wr_ctrl_i,
  input  logic [31:0]       wdata_i,
  input  logic              rd_eoi_i,
  input  logic              en_on_i,
  input  logic              en_off_i,
  output logic [CNT_W-1:0]  load_o,
  output logic [CNT_W-1:0]  cur_o,
  output logic [31:0]       ctrl_o,
  output logic              raw_o,
  output logic              trig_o,
  output logic              intr_o
);
  import timer_multi_pkg::*;

  logic               en_q, en_d, mask_q, mask_d, oneshot_q, oneshot_d;
  logic               raw_q, raw_d, trig_q, trig_d;
  mode_e              mode_q, mode_d;
  logic [PRESC_W-1:0] presc_q, presc_d, pcnt_q, pcnt_d;
  logic [CNT_W-1:0]   load_q, load_d, cur_q, cur_d, reload_val;
  logic               tick, expire;
  logic               unused_wdata;

  assign unused_wdata = ^wdata_i;

  always_comb begin
    tick   = en_q && (pcnt_q >= presc_q);
    expire = tick && (cur_q == '0);

    en_d      = en_q;
    mode_d    = mode_q;
    mask_d    = mask_q;
    oneshot_d = oneshot_q;
    presc_d   = presc_q;
    if (expire && oneshot_q) en_d = 1'b0;
    if (wr_ctrl_i) begin
      en_d      = wdata_i[CTRL_EN];
      mode_d    = mode_e'(wdata_i[CTRL_MODE]);
      mask_d    = wdata_i[CTRL_MASK];
      oneshot_d = wdata_i[CTRL_ONESHOT];
      presc_d   = wdata_i[CTRL_PRESC +: PRESC_W];
    end
    // ETB off is applied last so it beats both the bus write and ETB on
    if (en_on_i)  en_d = 1'b1;
    if (en_off_i) en_d = 1'b0;

    load_d     = wr_load_i ? wdata_i[CNT_W-1:0] : load_q;
    reload_val = (mode_d == USER_DEF) ? load_d : '1;

    cur_d  = cur_q;
    pcnt_d = pcnt_q;
    if (en_q) begin
      pcnt_d = tick ? '0 : pcnt_q + 1'b1;
      if (expire)    cur_d = oneshot_q ? '0 : reload_val;
      else if (tick) cur_d = cur_q - 1'b1;
    end
    if (en_d && !en_q) begin
      cur_d  = reload_val;
      pcnt_d = '0;
    end

    raw_d  = (raw_q && !rd_eoi_i) || expire;
    trig_d = expire;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      en_q      <= 1'b0;
      mode_q    <= FREE_RUN;
      mask_q    <= 1'b0;
      oneshot_q <= 1'b0;
      presc_q   <= '0;
      pcnt_q    <= '0;
      load_q    <= '0;
      cur_q     <= '0;
      raw_q     <= 1'b0;
      trig_q    <= 1'b0;
    end else begin
      en_q      <= en_d;
      mode_q    <= mode_d;
      mask_q    <= mask_d;
      oneshot_q <= oneshot_d;
      presc_q   <= presc_d;
      pcnt_q    <= pcnt_d;
      load_q    <= load_d;
      cur_q     <= cur_d;
      raw_q     <= raw_d;
      trig_q    <= trig_d;
    end
  end

  assign load_o = load_q;
  assign cur_o  = cur_q;
  assign ctrl_o = 32'({presc_q, 4'b0000, oneshot_q, mask_q, logic'(mode_q), en_q});
  assign raw_o  = raw_q;
  assign trig_o = trig_q;
  assign intr_o = raw_q && !mask_q;

endmodule

// File: rtl/apb_timer_multi.sv
// Multi-channel APB down-counting timer: APB decode and read mux around NUM_CH channel instances.
module apb_timer_multi #(
  parameter int NUM_CH  = 4,
  parameter int CNT_W   = 32,
  parameter int PRESC_W = 8
) (
  input  logic              pclk,
  input  logic              preset,
  apb_timer_multi_if.slave  apb,
  input  logic [NUM_CH-1:0] etb_trig_en_on,
  input  logic [NUM_CH-1:0] etb_trig_en_off,
  output logic [NUM_CH-1:0] tim_etb_trig,
  output logic [NUM_CH-1:0] intr
);
  import timer_multi_pkg::*;

  logic [3:0]        ch_idx, ch_off;
  logic              wr_acc, rd_acc, mapped;
  logic [31:0]       rdata;
  logic [NUM_CH-1:0] wr_load, wr_ctrl, rd_eoi, raw_vec;
  logic [CNT_W-1:0]  load_arr [NUM_CH];
  logic [CNT_W-1:0]  cur_arr  [NUM_CH];
  logic [31:0]       ctrl_arr [NUM_CH];

  assign ch_idx = apb.paddr[7:4];
  assign ch_off = apb.paddr[3:0];
  assign wr_acc = apb.psel && apb.penable && apb.pwrite;
  assign rd_acc = apb.psel && apb.penable && !apb.pwrite;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
    timer_multi_chan #(.CNT_W(CNT_W), .PRESC_W(PRESC_W)) u_chan (
      .clk_i     (pclk),
      .rst_i     (preset),
      .wr_load_i (wr_load[g]),
      .wr_ctrl_i (wr_ctrl[g]),
      .wdata_i   (apb.pwdata),
      .rd_eoi_i  (rd_eoi[g]),
      .en_on_i   (etb_trig_en_on[g]),
      .en_off_i  (etb_trig_en_off[g]),
      .load_o    (load_arr[g]),
      .cur_o     (cur_arr[g]),
      .ctrl_o    (ctrl_arr[g]),
      .raw_o     (raw_vec[g]),
      .trig_o    (tim_etb_trig[g]),
      .intr_o    (intr[g])
    );
  end

  // Channel windows below 0xA0 never alias the global block, even with 8 channels
  always_comb begin
    mapped  = 1'b0;
    rdata   = '0;
    wr_load = '0;
    wr_ctrl = '0;
    rd_eoi  = '0;
    for (int n = 0; n < NUM_CH; n++) begin
      if (ch_idx == 4'(n)) begin
        case (ch_off)
          OFF_LOAD:   begin mapped = 1'b1; rdata = 32'(load_arr[n]); wr_load[n] = wr_acc; end
          OFF_CURVAL: begin mapped = 1'b1; rdata = 32'(cur_arr[n]); end
          OFF_CTRL:   begin mapped = 1'b1; rdata = ctrl_arr[n]; wr_ctrl[n] = wr_acc; end
          OFF_EOI:    begin mapped = 1'b1; rdata = {31'b0, raw_vec[n]}; rd_eoi[n] = rd_acc; end
          default:    ;
        endcase
      end
    end
    case (apb.paddr)
      ADDR_INTSTAT: begin mapped = 1'b1; rdata = 32'(intr); end
      ADDR_EOI_ALL: begin mapped = 1'b1; rdata = 32'(raw_vec); rd_eoi = {NUM_CH{rd_acc}}; end
      ADDR_RAWINT:  begin mapped = 1'b1; rdata = 32'(raw_vec); end
      default:      ;
    endcase
  end

  assign apb.prdata  = (!preset && apb.psel && !apb.pwrite && mapped) ? rdata : '0;
  assign apb.pslverr = !preset && apb.psel && apb.penable && !mapped;
  assign apb.pready  = 1'b1;

endmodule

// File: tb/tb_apb_timer_multi.sv
// Scoreboard bench for apb_timer_multi: a 32-bit build plus an 8-bit build for the free-run wrap.
module tb_apb_timer_multi;
  logic pclk = 1'b0;
  logic preset = 1'b1;
  logic [3:0] en_on = '0, en_off = '0, zero_on = '0, zero_off = '0;
  logic [3:0] trig, intr, trig8, intr8;

  apb_timer_multi_if bus ();
  apb_timer_multi_if bus8 ();

  apb_timer_multi #(.NUM_CH(4), .CNT_W(32), .PRESC_W(8)) dut (
    .pclk(pclk), .preset(preset), .apb(bus),
    .etb_trig_en_on(en_on), .etb_trig_en_off(en_off),
    .tim_etb_trig(trig), .intr(intr)
  );

  apb_timer_multi #(.NUM_CH(4), .CNT_W(8), .PRESC_W(8)) dut8 (
    .pclk(pclk), .preset(preset), .apb(bus8),
    .etb_trig_en_on(zero_on), .etb_trig_en_off(zero_off),
    .tim_etb_trig(trig8), .intr(intr8)
  );

  always #5 pclk = ~pclk;

  int cyc = 0;
  always @(posedge pclk) cyc <= cyc + 1;

  int n_checks = 0, n_errors = 0;
  int exp_trig[$];
  logic [31:0] rd_exp_q[$];
  string rd_tag_q[$];
  logic last_err;
  int last_commit;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic bus_drive(input bit b8, input logic sel, input logic [7:0] a,
                           input logic w, input logic [31:0] d);
    bus.psel = sel && !b8;  bus8.psel = sel && b8;
    bus.paddr = a;          bus8.paddr = a;
    bus.pwrite = w;         bus8.pwrite = w;
    bus.pwdata = d;         bus8.pwdata = d;
    bus.penable = 1'b0;     bus8.penable = 1'b0;
  endtask

  task automatic apb_write(input bit b8, input logic [7:0] a, input logic [31:0] d,
                           input logic [3:0] off = 4'h0);
    @(posedge pclk); #1 bus_drive(b8, 1'b1, a, 1'b1, d);
    @(posedge pclk); #1 bus.penable = 1'b1; bus8.penable = 1'b1; en_off = off;
    #3 last_err = b8 ? bus8.pslverr : bus.pslverr;
    @(posedge pclk); #1 bus_drive(b8, 1'b0, 8'h00, 1'b0, 32'h0); en_off = '0;
    last_commit = cyc;
  endtask

  task automatic apb_read(input bit b8, input logic [7:0] a, input logic [31:0] exp,
                          input string tag);
    logic [31:0] got;
    @(posedge pclk); #1 bus_drive(b8, 1'b1, a, 1'b0, 32'h0);
    rd_exp_q.push_back(exp);
    rd_tag_q.push_back(tag);
    @(posedge pclk); #1 bus.penable = 1'b1; bus8.penable = 1'b1;
    #3 got = b8 ? bus8.prdata : bus.prdata;
    last_err = b8 ? bus8.pslverr : bus.pslverr;
    check(rd_tag_q.pop_front(), got, rd_exp_q.pop_front());
    @(posedge pclk); #1 bus_drive(b8, 1'b0, 8'h00, 1'b0, 32'h0);
  endtask

  task automatic pulse(input logic [3:0] on, input logic [3:0] off);
    @(posedge pclk); #1 en_on = on; en_off = off;
    @(posedge pclk); #1 en_on = '0; en_off = '0;
    last_commit = cyc;
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge pclk);
  endtask

  task automatic trig_seen(input int key);
    int idx = -1;
    foreach (exp_trig[i]) if (exp_trig[i] == key) idx = i;
    check($sformatf("trig_cyc%0d_ch%0d", key / 16, key % 16), 32'(idx >= 0), 32'd1);
    if (idx >= 0) exp_trig.delete(idx);
  endtask

  // key = cycle*16 + channel; channels 8..11 belong to the 8-bit build
  always @(negedge pclk) begin
    if (!preset) begin
      for (int n = 0; n < 4; n++) begin
        if (trig[n])  trig_seen(cyc * 16 + n);
        if (trig8[n]) trig_seen(cyc * 16 + 8 + n);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int c0, cd, c1, cc, ce, coff, c8, exp_cur;
    bus_drive(1'b0, 1'b0, 8'h00, 1'b0, 32'h0);
    repeat (3) @(posedge pclk);
    #1 preset = 1'b0;

    check("rst_intr", 32'(intr), 32'h0);
    check("rst_trig", 32'(trig), 32'h0);
    apb_read(0, 8'h04, 32'h0, "rst_curval0");
    check("rst_pslverr", 32'(last_err), 32'h0);
    apb_read(0, 8'h08, 32'h0, "rst_ctrl0");
    apb_read(0, 8'hA8, 32'h0, "rst_raw");

    // ch0 user mode, LOAD=5, PRESC=0
    apb_write(0, 8'h00, 32'd5);
    apb_write(0, 8'h08, 32'h3);
    c0 = last_commit;
    exp_trig.push_back((c0 + 6) * 16 + 0);
    exp_trig.push_back((c0 + 12) * 16 + 0);
    apb_read(0, 8'h04, 32'd3, "ch0_cur_count");
    check("ch0_intr_pre", 32'(intr[0]), 32'h0);
    wait_cyc(c0 + 6);
    check("ch0_intr_post", 32'(intr[0]), 32'h1);
    apb_read(0, 8'h04, 32'd3, "ch0_cur_reload");
    wait_cyc(c0 + 12);
    apb_write(0, 8'h08, 32'h2);
    cd = last_commit;
    exp_cur = 5 - (cd - (c0 + 12));
    apb_read(0, 8'h04, 32'(exp_cur), "ch0_cur_frozen");
    apb_read(0, 8'hA0, 32'h1, "ch0_intstat");
    apb_read(0, 8'h0C, 32'h1, "ch0_eoi");
    apb_read(0, 8'hA8, 32'h0, "ch0_raw_cleared");
    check("ch0_intr_cleared", 32'(intr[0]), 32'h0);

    // ch1 one-shot, LOAD=3, PRESC=2
    apb_write(0, 8'h10, 32'd3);
    apb_write(0, 8'h18, 32'h20B);
    c1 = last_commit;
    exp_trig.push_back((c1 + 12) * 16 + 1);
    wait_cyc(c1 + 13);
    apb_read(0, 8'h18, 32'h20A, "ch1_en_cleared");
    apb_read(0, 8'h14, 32'h0, "ch1_cur_zero");
    check("ch1_intr", 32'(intr[1]), 32'h1);
    wait_cyc(c1 + 65);
    apb_read(0, 8'h14, 32'h0, "ch1_cur_held");
    apb_read(0, 8'h1C, 32'h1, "ch1_eoi");
    apb_read(0, 8'hA8, 32'h0, "ch1_raw_cleared");

    // ch0 masked, LOAD=2: EOI read lands on an expiry edge
    apb_write(0, 8'h00, 32'd2);
    apb_write(0, 8'h08, 32'h7);
    cc = last_commit;
    for (int k = 1; k <= 5; k++) exp_trig.push_back((cc + 3 * k) * 16 + 0);
    wait_cyc(cc + 3);
    apb_read(0, 8'hA0, 32'h0, "mask_intstat");
    apb_read(0, 8'h0C, 32'h1, "mask_eoi_coincident");
    apb_read(0, 8'hA8, 32'h1, "mask_raw_set_wins");
    apb_write(0, 8'h08, 32'h6);
    check("mask_intr_low", 32'(intr[0]), 32'h0);
    apb_write(0, 8'h08, 32'h2);
    check("unmask_intr_high", 32'(intr[0]), 32'h1);
    apb_read(0, 8'h0C, 32'h1, "mask_eoi");
    apb_read(0, 8'hA8, 32'h0, "mask_raw_cleared");
    check("mask_intr_cleared", 32'(intr[0]), 32'h0);

    // ch3 ETB enable control, LOAD=4
    apb_write(0, 8'h30, 32'd4);
    apb_write(0, 8'h38, 32'h2);
    pulse(4'h8, 4'h0);
    ce = last_commit;
    exp_trig.push_back((ce + 5) * 16 + 3);
    apb_read(0, 8'h34, 32'd2, "ch3_etb_start");
    wait_cyc(ce + 6);
    pulse(4'h0, 4'h8);
    coff = last_commit;
    exp_cur = 4 - (coff - (ce + 5));
    apb_read(0, 8'h34, 32'(exp_cur), "ch3_cur_off");
    apb_read(0, 8'h38, 32'h2, "ch3_en_off");
    pulse(4'h8, 4'h8);
    apb_read(0, 8'h38, 32'h2, "ch3_on_off_same");
    apb_write(0, 8'h38, 32'h3, 4'h8);
    check("ch3_wr_pslverr", 32'(last_err), 32'h0);
    apb_read(0, 8'h38, 32'h2, "ch3_wr_vs_off");
    apb_read(0, 8'h34, 32'(exp_cur), "ch3_cur_still");
    check("ch3_intr", 32'(intr[3]), 32'h1);

    // unmapped accesses
    apb_read(0, 8'h50, 32'h0, "unmapped_rd_data");
    check("unmapped_rd_err", 32'(last_err), 32'h1);
    apb_write(0, 8'h50, 32'hFF);
    check("unmapped_wr_err", 32'(last_err), 32'h1);
    apb_read(0, 8'h10, 32'd3, "ch1_load_kept");
    check("mapped_err", 32'(last_err), 32'h0);
    apb_read(0, 8'h02, 32'h0, "unaligned_data");
    check("unaligned_err", 32'(last_err), 32'h1);

    // 8-bit build, ch2 free-run
    apb_write(1, 8'h28, 32'h1);
    c8 = last_commit;
    exp_trig.push_back((c8 + 256) * 16 + 8 + 2);
    apb_read(1, 8'h24, 32'hFD, "w8_cur_start");
    wait_cyc(c8 + 256);
    apb_read(1, 8'h24, 32'hFD, "w8_cur_reload");
    apb_read(1, 8'hA8, 32'h4, "w8_raw");
    apb_write(1, 8'h28, 32'h0);

    // reset while ch0 counts
    check("pre_rst_intr", 32'(intr), 32'h8);
    check("pre_rst_intr8", 32'(intr8), 32'h4);
    apb_write(0, 8'h08, 32'h3);
    @(negedge pclk) preset = 1'b1;
    @(negedge pclk);
    check("rst_mid_intr", 32'(intr), 32'h0);
    check("rst_mid_trig", 32'(trig), 32'h0);
    check("rst_mid_intr8", 32'(intr8), 32'h0);
    @(negedge pclk) preset = 1'b0;
    apb_read(0, 8'h04, 32'h0, "rst_mid_cur0");
    apb_read(0, 8'h08, 32'h0, "rst_mid_ctrl0");
    apb_read(0, 8'h00, 32'h0, "rst_mid_load0");
    apb_read(0, 8'hA8, 32'h0, "rst_mid_raw");
    apb_read(1, 8'h24, 32'h0, "rst_mid_cur8");

    check("trig_pending", 32'(exp_trig.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
